// File: rtl/zbus_strobe_seq.sv
// ---------------------------------------------------------------------------
// zbus_strobe_seq
//
// Access sequencer between the Z80 bus decode and the W5300/SL811 chip bus.
// The raw asynchronous Z80 IORQ/RD/WR strobes are brought into the fclk
// domain through a 3-flop chain with a two-sample agreement filter. From the
// filtered levels a small FSM produces fixed-width chip read/write strobes,
// drives the chip data bus during writes, captures chip read data for the
// Z80, and inserts a recovery gap before the next access is accepted.
//
// Parameters:
//   RD_CYCLES     brd_n low width in fclk cycles (1..15)
//   WR_CYCLES     bwr_n low width in fclk cycles (1..15)
//   RECOV_CYCLES  recovery count loaded after each access (0..15)
//
// Ports:
//   fclk        in   filter / system clock (sole clock)
//   rst         in   synchronous active-high reset
//   ziorq_n     in   raw Z80 IORQ, asynchronous
//   zrd_n       in   raw Z80 RD, asynchronous
//   zwr_n       in   raw Z80 WR, asynchronous
//   sel         in   address decoder hit, stable while IORQ is low
//   zd_in[7:0]  in   Z80 data bus, stable while WR is low
//   bd_in[7:0]  in   chip data bus input
//   brd_n       out  chip read strobe (registered)
//   bwr_n       out  chip write strobe (registered)
//   bd_oe       out  drive chip data bus with bd_out (registered)
//   bd_out[7:0] out  write data latched at access start
//   rd_data[7:0]out  last byte captured from the chip
//   acc_active  out  high from access start to end of recovery
// ---------------------------------------------------------------------------
module zbus_strobe_seq #(
    parameter int RD_CYCLES    = 4,
    parameter int WR_CYCLES    = 3,
    parameter int RECOV_CYCLES = 2
) (
    input  logic       fclk,
    input  logic       rst,
    input  logic       ziorq_n,
    input  logic       zrd_n,
    input  logic       zwr_n,
    input  logic       sel,
    input  logic [7:0] zd_in,
    input  logic [7:0] bd_in,
    output logic       brd_n,
    output logic       bwr_n,
    output logic       bd_oe,
    output logic [7:0] bd_out,
    output logic [7:0] rd_data,
    output logic       acc_active
);

    typedef enum logic [2:0] {
        IDLE,
        RD_STB,
        WR_SETUP,
        WR_STB,
        WR_HOLD,
        WAIT_END,
        RECOV
    } state_e;

    localparam logic [3:0] RD_LOAD    = 4'(RD_CYCLES - 1);
    localparam logic [3:0] WR_LOAD    = 4'(WR_CYCLES - 1);
    localparam logic [3:0] RECOV_LOAD = 4'(RECOV_CYCLES);

    // Strobe vector bit order: [0] iorq, [1] rd, [2] wr. All active low.
    logic [2:0] raw_n;
    logic [2:0] s1_q, s2_q, s3_q;
    logic [2:0] filt_q, filt_d;
    logic       rd_act, wr_act;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       cap_rd, latch_wr;

    logic       brd_n_q, brd_n_d;
    logic       bwr_n_q, bwr_n_d;
    logic       bd_oe_q, bd_oe_d;
    logic       acc_q, acc_d;
    logic [7:0] bd_out_q, bd_out_d;
    logic [7:0] rd_data_q, rd_data_d;

    assign raw_n = {zwr_n, zrd_n, ziorq_n};

    // Agreement filter: follow s2/s3 when they match, otherwise hold. Taken
    // combinationally from s2/s3 so the FSM reacts on the edge after s3
    // settles, giving the 4-edge start latency.
    assign filt_d = (s2_q & s3_q) | (filt_q & (s2_q | s3_q));
    assign rd_act = ~filt_d[0] & ~filt_d[1];
    assign wr_act = ~filt_d[0] & ~filt_d[2];

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its sources, independent of statement order.
    always_ff @(posedge fclk) begin
        if (rst) begin
            // Synchroniser and filter preset to the inactive level, so a strobe
            // already low at reset release is seen as a fresh edge 3 cycles later.
            s1_q      <= 3'b111;
            s2_q      <= 3'b111;
            s3_q      <= 3'b111;
            filt_q    <= 3'b111;
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            brd_n_q   <= 1'b1;
            bwr_n_q   <= 1'b1;
            bd_oe_q   <= 1'b0;
            acc_q     <= 1'b0;
            bd_out_q  <= 8'h00;
            rd_data_q <= 8'h00;
        end else begin
            s1_q      <= raw_n;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            filt_q    <= filt_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            brd_n_q   <= brd_n_d;
            bwr_n_q   <= bwr_n_d;
            bd_oe_q   <= bd_oe_d;
            acc_q     <= acc_d;
            bd_out_q  <= bd_out_d;
            rd_data_q <= rd_data_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cap_rd   = 1'b0;
        latch_wr = 1'b0;

        case (state_q)
            IDLE: begin
                if (rd_act && wr_act && sel) begin
                    // Simultaneous RD and WR is a bus fault: no chip cycle.
                    state_d = IDLE;
                end else if (rd_act && sel) begin
                    state_d = RD_STB;
                    cnt_d   = RD_LOAD;
                end else if (wr_act && sel) begin
                    state_d  = WR_SETUP;
                    latch_wr = 1'b1;
                end else if (rd_act || wr_act) begin
                    // Not our address: track the strobe so acc_active covers it.
                    state_d = WAIT_END;
                end
            end

            RD_STB: begin
                if (cnt_q == 4'd0) begin
                    cap_rd  = 1'b1;
                    state_d = WAIT_END;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            WR_SETUP: begin
                state_d = WR_STB;
                cnt_d   = WR_LOAD;
            end

            WR_STB: begin
                if (cnt_q == 4'd0) begin
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            WR_HOLD: begin
                state_d = WAIT_END;
            end

            WAIT_END: begin
                if (!rd_act && !wr_act) begin
                    if (RECOV_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = RECOV;
                        cnt_d   = RECOV_LOAD;
                    end
                end
            end

            RECOV: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic: decoded from the next state and registered above, so the
    // pins change on the same edge as the state and have no input-to-output
    // combinational path.
    // -----------------------------------------------------------------------
    always_comb begin
        brd_n_d = 1'b1;
        bwr_n_d = 1'b1;
        bd_oe_d = 1'b0;
        acc_d   = (state_d != IDLE);

        case (state_d)
            RD_STB:   brd_n_d = 1'b0;
            WR_SETUP: bd_oe_d = 1'b1;
            WR_STB: begin
                bd_oe_d = 1'b1;
                bwr_n_d = 1'b0;
            end
            WR_HOLD:  bd_oe_d = 1'b1;
            default: begin
                brd_n_d = 1'b1;
                bwr_n_d = 1'b1;
                bd_oe_d = 1'b0;
            end
        endcase

        bd_out_d  = latch_wr ? zd_in : bd_out_q;
        rd_data_d = cap_rd   ? bd_in : rd_data_q;
    end

    assign brd_n      = brd_n_q;
    assign bwr_n      = bwr_n_q;
    assign bd_oe      = bd_oe_q;
    assign acc_active = acc_q;
    assign bd_out     = bd_out_q;
    assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_zbus_strobe_seq.sv
// ---------------------------------------------------------------------------
// tb_zbus_strobe_seq
//
// Directed bench for zbus_strobe_seq with default parameters
// (RD_CYCLES=4, WR_CYCLES=3, RECOV_CYCLES=2). Inputs change 1 ns after a
// rising edge; outputs are sampled at the same point. Edge numbers in the
// comments count rising edges after the stimulus change.
// ---------------------------------------------------------------------------
module tb_zbus_strobe_seq;

    logic       fclk;
    logic       rst;
    logic       ziorq_n;
    logic       zrd_n;
    logic       zwr_n;
    logic       sel;
    logic [7:0] zd_in;
    logic [7:0] bd_in;
    logic       brd_n;
    logic       bwr_n;
    logic       bd_oe;
    logic [7:0] bd_out;
    logic [7:0] rd_data;
    logic       acc_active;

    int vectors;
    int miscompares;

    zbus_strobe_seq #(
        .RD_CYCLES   (4),
        .WR_CYCLES   (3),
        .RECOV_CYCLES(2)
    ) dut (
        .fclk      (fclk),
        .rst       (rst),
        .ziorq_n   (ziorq_n),
        .zrd_n     (zrd_n),
        .zwr_n     (zwr_n),
        .sel       (sel),
        .zd_in     (zd_in),
        .bd_in     (bd_in),
        .brd_n     (brd_n),
        .bwr_n     (bwr_n),
        .bd_oe     (bd_oe),
        .bd_out    (bd_out),
        .rd_data   (rd_data),
        .acc_active(acc_active)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    task automatic step();
        @(posedge fclk);
        #1;
    endtask

    // Releases all strobes and waits (bounded) for the sequencer to go idle,
    // then lets the synchronisers settle.
    task automatic wait_idle(output bit ok);
        int n;
        ziorq_n = 1'b1;
        zrd_n   = 1'b1;
        zwr_n   = 1'b1;
        n = 0;
        while (acc_active !== 1'b0 && n < 50) begin
            step();
            n++;
        end
        ok = (acc_active === 1'b0);
        repeat (4) step();
    endtask

    task automatic test_reset();
        int n;
        bit ok;
        rst = 1'b1; ziorq_n = 1'b0; zrd_n = 1'b0; sel = 1'b1; bd_in = 8'h11;
        repeat (3) step();
        vectors++;
        if ({brd_n, bwr_n, bd_oe, acc_active} !== 4'b1100) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b required 1100", {brd_n, bwr_n, bd_oe, acc_active});
        end
        vectors++;
        if (bd_out !== 8'h00 || rd_data !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_data: got bd_out=%h rd_data=%h required 00/00", bd_out, rd_data);
        end
        rst = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            step();
            vectors++;
            if (brd_n !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_early_brd edge %0d: got %b required 1", e, brd_n);
            end
        end
        step();
        vectors++;
        if (brd_n !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_brd_edge4: got %b required 0", brd_n);
        end
        n = 0;
        while (brd_n === 1'b0 && n < 20) begin
            n++;
            step();
        end
        vectors++;
        if (n != 4 || rd_data !== 8'h11) begin
            miscompares++;
            $display("FAIL reset_read: got width=%0d rd_data=%h required 4/11", n, rd_data);
        end
        wait_idle(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL reset_idle: got acc_active=%b required 0", acc_active);
        end
    endtask

    task automatic test_read();
        int e;
        int n;
        sel = 1'b1; bd_in = 8'hA5; ziorq_n = 1'b0; zrd_n = 1'b0;
        e = 0;
        while (brd_n !== 1'b0 && e < 20) begin
            step();
            e++;
        end
        vectors++;
        if (e != 4) begin
            miscompares++;
            $display("FAIL read_latency: got %0d edges required 4", e);
        end
        vectors++;
        if (rd_data !== 8'h11 || acc_active !== 1'b1) begin
            miscompares++;
            $display("FAIL read_during: got rd_data=%h acc=%b required 11/1", rd_data, acc_active);
        end
        n = 0;
        while (brd_n === 1'b0 && n < 20) begin
            n++;
            step();
        end
        vectors++;
        if (n != 4) begin
            miscompares++;
            $display("FAIL read_width: got %0d required 4", n);
        end
        vectors++;
        if (rd_data !== 8'hA5) begin
            miscompares++;
            $display("FAIL read_data: got %h required a5", rd_data);
        end
        bd_in = 8'hFF;
        // Release: filter clears after edge 3, RECOV entered at 4, idle at 7.
        ziorq_n = 1'b1; zrd_n = 1'b1;
        repeat (6) step();
        vectors++;
        if (acc_active !== 1'b1) begin
            miscompares++;
            $display("FAIL read_recov_hold: got acc=%b required 1", acc_active);
        end
        step();
        vectors++;
        if (acc_active !== 1'b0 || rd_data !== 8'hA5) begin
            miscompares++;
            $display("FAIL read_recov_end: got acc=%b rd_data=%h required 0/a5", acc_active, rd_data);
        end
        repeat (4) step();
    endtask

    task automatic test_write();
        int oe_cnt, wr_cnt, first_oe, first_wr;
        bit rd_seen;
        bit ok;
        oe_cnt = 0; wr_cnt = 0; first_oe = 0; first_wr = 0; rd_seen = 1'b0;
        sel = 1'b1; zd_in = 8'h3C; ziorq_n = 1'b0; zwr_n = 1'b0;
        for (int e = 1; e <= 14; e++) begin
            step();
            if (bd_oe === 1'b1) begin
                oe_cnt++;
                if (first_oe == 0) first_oe = e;
            end
            if (bwr_n === 1'b0) begin
                wr_cnt++;
                if (first_wr == 0) first_wr = e;
            end
            if (brd_n !== 1'b1) rd_seen = 1'b1;
        end
        vectors++;
        if (oe_cnt != 5 || first_oe != 4) begin
            miscompares++;
            $display("FAIL write_oe: got count=%0d start=%0d required 5/4", oe_cnt, first_oe);
        end
        vectors++;
        if (wr_cnt != 3 || first_wr != 5) begin
            miscompares++;
            $display("FAIL write_bwr: got count=%0d start=%0d required 3/5", wr_cnt, first_wr);
        end
        vectors++;
        if (bd_out !== 8'h3C || rd_data !== 8'hA5 || rd_seen) begin
            miscompares++;
            $display("FAIL write_data: got bd_out=%h rd_data=%h brd_seen=%b required 3c/a5/0",
                     bd_out, rd_data, rd_seen);
        end
        wait_idle(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL write_idle: got acc_active=%b required 0", acc_active);
        end
    endtask

    task automatic test_unselected();
        bit strobe_seen, acc_seen, ok;
        strobe_seen = 1'b0; acc_seen = 1'b0;
        sel = 1'b0; bd_in = 8'h5A; ziorq_n = 1'b0; zrd_n = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            step();
            if (brd_n !== 1'b1 || bwr_n !== 1'b1 || bd_oe !== 1'b0) strobe_seen = 1'b1;
            if (acc_active === 1'b1) acc_seen = 1'b1;
        end
        vectors++;
        if (strobe_seen || !acc_seen) begin
            miscompares++;
            $display("FAIL unsel_strobes: got strobe=%b acc=%b required 0/1", strobe_seen, acc_seen);
        end
        wait_idle(ok);
        vectors++;
        if (!ok || rd_data !== 8'hA5) begin
            miscompares++;
            $display("FAIL unsel_end: got idle=%b rd_data=%h required 1/a5", ok, rd_data);
        end
    endtask

    task automatic test_glitch();
        bit activity;
        bit ok;
        // One-cycle RD pulse never gives s2/s3 agreement.
        activity = 1'b0;
        sel = 1'b1; bd_in = 8'h77; ziorq_n = 1'b0; zrd_n = 1'b0;
        step();
        ziorq_n = 1'b1; zrd_n = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            step();
            if (brd_n !== 1'b1 || acc_active !== 1'b0) activity = 1'b1;
        end
        vectors++;
        if (activity) begin
            miscompares++;
            $display("FAIL glitch: got activity=1 required 0");
        end
        // RD and WR together on a selected address: ignored as a bus fault.
        activity = 1'b0;
        zd_in = 8'hE7; ziorq_n = 1'b0; zrd_n = 1'b0; zwr_n = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            step();
            if (brd_n !== 1'b1 || bwr_n !== 1'b1 || bd_oe !== 1'b0 || acc_active !== 1'b0)
                activity = 1'b1;
        end
        vectors++;
        if (activity || bd_out !== 8'h3C || rd_data !== 8'hA5) begin
            miscompares++;
            $display("FAIL fault_ignore: got activity=%b bd_out=%h rd_data=%h required 0/3c/a5",
                     activity, bd_out, rd_data);
        end
        wait_idle(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL fault_idle: got acc_active=%b required 0", acc_active);
        end
    endtask

    task automatic test_reset_mid_read();
        int e;
        bit ok, brd_seen;
        sel = 1'b1; bd_in = 8'h42; ziorq_n = 1'b0; zrd_n = 1'b0;
        e = 0;
        while (brd_n !== 1'b0 && e < 20) begin
            step();
            e++;
        end
        step();
        vectors++;
        if (brd_n !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_pre: got brd_n=%b required 0", brd_n);
        end
        rst = 1'b1;
        step();
        vectors++;
        if ({brd_n, bwr_n, bd_oe, acc_active} !== 4'b1100 || rd_data !== 8'h00 || bd_out !== 8'h00) begin
            miscompares++;
            $display("FAIL midrst_next_edge: got ctrl=%b rd_data=%h bd_out=%h required 1100/00/00",
                     {brd_n, bwr_n, bd_oe, acc_active}, rd_data, bd_out);
        end
        rst = 1'b0;
        ziorq_n = 1'b1; zrd_n = 1'b1;
        brd_seen = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (brd_n !== 1'b1) brd_seen = 1'b1;
        end
        wait_idle(ok);
        vectors++;
        if (!ok || brd_seen) begin
            miscompares++;
            $display("FAIL midrst_after: got idle=%b brd_seen=%b required 1/0", ok, brd_seen);
        end
    endtask

    task automatic test_back_to_back();
        int e, n;
        bit ok;
        sel = 1'b1; zd_in = 8'h96; bd_in = 8'hC3; ziorq_n = 1'b0; zwr_n = 1'b0;
        repeat (10) step();
        vectors++;
        if (bwr_n !== 1'b1 || bd_oe !== 1'b0 || bd_out !== 8'h96) begin
            miscompares++;
            $display("FAIL b2b_write: got bwr_n=%b bd_oe=%b bd_out=%h required 1/0/96",
                     bwr_n, bd_oe, bd_out);
        end
        // One-cycle gap, then read. WR filter clears after edge 3, RECOV
        // runs edges 4..6, IDLE at 7, brd_n falls at edge 8.
        ziorq_n = 1'b1; zwr_n = 1'b1;
        step();
        ziorq_n = 1'b0; zrd_n = 1'b0;
        e = 1;
        while (brd_n !== 1'b0 && e < 30) begin
            step();
            e++;
        end
        vectors++;
        if (e != 8) begin
            miscompares++;
            $display("FAIL b2b_spacing: got brd_n fall at edge %0d required 8", e);
        end
        n = 0;
        while (brd_n === 1'b0 && n < 20) begin
            n++;
            step();
        end
        vectors++;
        if (n != 4 || rd_data !== 8'hC3) begin
            miscompares++;
            $display("FAIL b2b_read: got width=%0d rd_data=%h required 4/c3", n, rd_data);
        end
        wait_idle(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL b2b_idle: got acc_active=%b required 0", acc_active);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst     = 1'b0;
        ziorq_n = 1'b1;
        zrd_n   = 1'b1;
        zwr_n   = 1'b1;
        sel     = 1'b0;
        zd_in   = 8'h00;
        bd_in   = 8'h00;
        #2;
        test_reset();
        test_read();
        test_write();
        test_unselected();
        test_glitch();
        test_reset_mid_read();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
